// File: rtl/dec_fpr_wb_ctl.sv
// dec_fpr_wb_ctl: merges FPU, FP load and divide results onto two FPR write ports,
// resolving same-address collisions and back-pressuring the divider.
module dec_fpr_wb_ctl #(
    parameter int FLEN         = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fpu_wb_valid,
    input  logic [4:0]      fpu_wb_addr,
    input  logic [FLEN-1:0] fpu_wb_data,
    input  logic            ld_wb_valid,
    input  logic [4:0]      ld_wb_addr,
    input  logic [FLEN-1:0] ld_wb_data,
    input  logic            ld_younger,
    input  logic            div_valid,
    input  logic [4:0]      div_addr,
    input  logic [FLEN-1:0] div_data,
    output logic            div_ready,
    output logic            div_drop,
    output logic            wb_stall,
    output logic            wen0,
    output logic [4:0]      waddr0,
    output logic [FLEN-1:0] wd0,
    output logic            wen1,
    output logic [4:0]      waddr1,
    output logic [FLEN-1:0] wd1,
    output logic            wb_idle
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic            w_coll, w_fpu_wr, w_ld_wr, w_acc, w_drop, w_div_p0, w_div_p1;
    logic            w_wen0, w_wen1;
    logic [7:0]      w_cnt_nxt;
    logic [7:0]      r_cnt;
    logic            r_wen0, r_wen1, r_drop, r_stall, r_idle;
    logic [4:0]      r_waddr0, r_waddr1;
    logic [FLEN-1:0] r_wd0, r_wd1;

    // On a same-address collision only the younger result survives; the loser's port frees up
    always_comb begin
        w_coll    = fpu_wb_valid & ld_wb_valid & (fpu_wb_addr == ld_wb_addr);
        w_fpu_wr  = fpu_wb_valid & ~(w_coll & ld_younger);
        w_ld_wr   = ld_wb_valid & ~(w_coll & ~ld_younger);
        div_ready = div_valid & (~w_fpu_wr | ~w_ld_wr) & ~rst;
        w_acc     = div_valid & div_ready;
        w_drop    = w_acc & ((w_fpu_wr & (div_addr == fpu_wb_addr)) |
                             (w_ld_wr & (div_addr == ld_wb_addr)));
        w_div_p0  = w_acc & ~w_drop & ~w_fpu_wr;
        w_div_p1  = w_acc & ~w_drop & w_fpu_wr;
        w_wen0    = w_fpu_wr | w_div_p0;
        w_wen1    = w_ld_wr | w_div_p1;
        w_cnt_nxt = (~div_valid | w_acc) ? 8'd0 : (r_cnt == LIMIT) ? r_cnt : r_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen0   <= 1'b0;
            r_wen1   <= 1'b0;
            r_waddr0 <= '0;
            r_waddr1 <= '0;
            r_wd0    <= '0;
            r_wd1    <= '0;
            r_drop   <= 1'b0;
            r_stall  <= 1'b0;
            r_idle   <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_wen0   <= w_wen0;
            r_wen1   <= w_wen1;
            r_waddr0 <= w_fpu_wr ? fpu_wb_addr : div_addr;
            r_waddr1 <= w_ld_wr ? ld_wb_addr : div_addr;
            r_wd0    <= w_fpu_wr ? fpu_wb_data : div_data;
            r_wd1    <= w_ld_wr ? ld_wb_data : div_data;
            r_drop   <= w_drop;
            r_stall  <= (w_cnt_nxt == LIMIT);
            r_idle   <= ~r_wen0 & ~r_wen1 & ~div_valid;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign wen0     = r_wen0;
    assign wen1     = r_wen1;
    assign waddr0   = r_waddr0;
    assign waddr1   = r_waddr1;
    assign wd0      = r_wd0;
    assign wd1      = r_wd1;
    assign div_drop = r_drop;
    assign wb_stall = r_stall;
    assign wb_idle  = r_idle;
endmodule

// File: tb/tb_dec_fpr_wb_ctl.sv
// tb_dec_fpr_wb_ctl: directed vectors with hand-computed expectations for dec_fpr_wb_ctl.
module tb_dec_fpr_wb_ctl;
    logic        clk = 1'b0;
    logic        rst;
    logic        fpu_wb_valid, ld_wb_valid, ld_younger, div_valid;
    logic [4:0]  fpu_wb_addr, ld_wb_addr, div_addr;
    logic [63:0] fpu_wb_data, ld_wb_data, div_data;
    logic        div_ready, div_drop, wb_stall, wen0, wen1, wb_idle;
    logic [4:0]  waddr0, waddr1;
    logic [63:0] wd0, wd1;
    int          n_chk = 0;
    int          n_err = 0;

    dec_fpr_wb_ctl #(.FLEN(64), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .fpu_wb_valid(fpu_wb_valid), .fpu_wb_addr(fpu_wb_addr), .fpu_wb_data(fpu_wb_data),
        .ld_wb_valid(ld_wb_valid), .ld_wb_addr(ld_wb_addr), .ld_wb_data(ld_wb_data),
        .ld_younger(ld_younger),
        .div_valid(div_valid), .div_addr(div_addr), .div_data(div_data),
        .div_ready(div_ready), .div_drop(div_drop), .wb_stall(wb_stall),
        .wen0(wen0), .waddr0(waddr0), .wd0(wd0),
        .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
        .wb_idle(wb_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        fpu_wb_valid = 0; ld_wb_valid = 0; div_valid = 0; ld_younger = 0;
        fpu_wb_addr = 0; ld_wb_addr = 0; div_addr = 0;
        fpu_wb_data = 0; ld_wb_data = 0; div_data = 0;
    endtask

    // Two ports must never write the same register in one cycle
    always @(negedge clk)
        if (wen0 && wen1) chk("same_addr_inv", 64'(waddr0 == waddr1), 64'd0);

    initial begin
        quiet();
        rst = 1;
        div_valid = 1; div_addr = 5'd2;
        #1;
        chk("rst_div_ready", 64'(div_ready), 0);
        tick(); tick();
        chk("rst_wen0", 64'(wen0), 0);
        chk("rst_wen1", 64'(wen1), 0);
        chk("rst_waddr0", 64'(waddr0), 0);
        chk("rst_wd1", wd1, 0);
        chk("rst_stall", 64'(wb_stall), 0);
        chk("rst_idle", 64'(wb_idle), 1);
        quiet();
        rst = 0;
        tick();

        fpu_wb_valid = 1; fpu_wb_addr = 3; fpu_wb_data = 64'h1111;
        ld_wb_valid = 1; ld_wb_addr = 5; ld_wb_data = 64'h2222;
        tick();
        chk("dual_wen0", 64'(wen0), 1);
        chk("dual_waddr0", 64'(waddr0), 3);
        chk("dual_wd0", wd0, 64'h1111);
        chk("dual_wen1", 64'(wen1), 1);
        chk("dual_waddr1", 64'(waddr1), 5);
        chk("dual_wd1", wd1, 64'h2222);

        fpu_wb_addr = 7; fpu_wb_data = 64'hA; ld_wb_addr = 7; ld_wb_data = 64'hB; ld_younger = 1;
        tick();
        chk("coll_ld_wen0", 64'(wen0), 0);
        chk("coll_ld_wen1", 64'(wen1), 1);
        chk("coll_ld_waddr1", 64'(waddr1), 7);
        chk("coll_ld_wd1", wd1, 64'hB);
        ld_younger = 0;
        tick();
        chk("coll_fpu_wen0", 64'(wen0), 1);
        chk("coll_fpu_wd0", wd0, 64'hA);
        chk("coll_fpu_wen1", 64'(wen1), 0);

        quiet();
        fpu_wb_valid = 1; fpu_wb_addr = 1; fpu_wb_data = 64'h5;
        div_valid = 1; div_addr = 9; div_data = 64'hD9;
        #1;
        chk("div_ready_p1", 64'(div_ready), 1);
        tick();
        chk("div_wen1", 64'(wen1), 1);
        chk("div_waddr1", 64'(waddr1), 9);
        chk("div_wd1", wd1, 64'hD9);
        chk("div_nodrop", 64'(div_drop), 0);
        fpu_wb_addr = 9;
        #1;
        chk("drop_ready", 64'(div_ready), 1);
        tick();
        chk("drop_pulse", 64'(div_drop), 1);
        chk("drop_wen1", 64'(wen1), 0);
        chk("drop_waddr0", 64'(waddr0), 9);
        chk("drop_wd0", wd0, 64'h5);
        quiet();
        tick();
        chk("drop_clear", 64'(div_drop), 0);

        div_valid = 1; div_addr = 10; div_data = 64'h10;
        tick();
        chk("b2b_a_addr", 64'(waddr0), 10);
        div_addr = 11; div_data = 64'h11;
        #1;
        chk("b2b_b_ready", 64'(div_ready), 1);
        tick();
        chk("b2b_b_wen0", 64'(wen0), 1);
        chk("b2b_b_addr", 64'(waddr0), 11);
        chk("b2b_b_data", wd0, 64'h11);
        quiet();
        tick();

        fpu_wb_valid = 1; fpu_wb_addr = 1; ld_wb_valid = 1; ld_wb_addr = 2;
        div_valid = 1; div_addr = 12; div_data = 64'hC12;
        for (int i = 1; i <= 12; i++) begin
            #1;
            chk("starve_ready", 64'(div_ready), 0);
            tick();
            chk($sformatf("starve_stall_%0d", i), 64'(wb_stall), 64'(i >= 8));
        end
        ld_wb_valid = 0;
        #1;
        chk("starve_accept", 64'(div_ready), 1);
        tick();
        chk("starve_wen1", 64'(wen1), 1);
        chk("starve_waddr1", 64'(waddr1), 12);
        chk("starve_stall_fall", 64'(wb_stall), 0);
        quiet();
        tick();

        fpu_wb_valid = 1; fpu_wb_addr = 4; fpu_wb_data = 64'h44;
        tick();
        chk("mid_wen0_pre", 64'(wen0), 1);
        quiet();
        div_valid = 1; div_addr = 6; div_data = 64'h66;
        rst = 1;
        #1;
        chk("mid_rst_wen0", 64'(wen0), 0);
        chk("mid_rst_waddr0", 64'(waddr0), 0);
        chk("mid_rst_wd0", wd0, 0);
        chk("mid_rst_idle", 64'(wb_idle), 1);
        chk("mid_rst_ready", 64'(div_ready), 0);
        tick();
        chk("mid_rst_hold", 64'(wen0), 0);
        rst = 0;
        #1;
        chk("post_rst_ready", 64'(div_ready), 1);
        tick();
        chk("post_rst_wen0", 64'(wen0), 1);
        chk("post_rst_waddr0", 64'(waddr0), 6);
        chk("post_rst_wd0", wd0, 64'h66);
        div_valid = 0;
        tick();
        chk("post_rst_once", 64'(wen0), 0);
        tick();
        chk("idle_quiet", 64'(wb_idle), 1);
        fpu_wb_valid = 1; fpu_wb_addr = 8;
        tick();
        fpu_wb_valid = 0;
        tick();
        chk("idle_busy", 64'(wb_idle), 0);
        tick();
        chk("idle_back", 64'(wb_idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
